// File: rtl/mac_sequencer_if.sv
// Handshake bundle between the MAC front end, the sequencer and the shared mul.
// The slave modport is the sequencer side; master is the environment driving it.
interface mac_sequencer_if #(
  parameter int OPSIZE = 8,
  parameter int ACCW   = 24,
  parameter int LENW   = 8
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [LENW-1:0]          cmd_len;
  logic                     op_valid;
  logic                     op_ready;
  logic signed [OPSIZE-1:0] op_a;
  logic signed [OPSIZE-1:0] op_b;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [ACCW-1:0]   res_data;
  logic                     res_ovf;
  logic                     busy;
  logic                     mul_start;
  logic signed [OPSIZE-1:0] mul_a;
  logic signed [OPSIZE-1:0] mul_b;
  logic signed [2*OPSIZE-1:0] mul_out;
  logic                     mul_ready;

  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready, mul_out, mul_ready,
    output cmd_ready, op_ready, res_valid, res_data, res_ovf, busy, mul_start, mul_a, mul_b
  );

  modport master (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready, mul_out, mul_ready,
    input  cmd_ready, op_ready, res_valid, res_data, res_ovf, busy, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mac_sequencer.sv
// Drives a shared iterative signed multiplier to compute a signed dot product
// of N operand pairs, accumulating with wrap and a sticky overflow flag.
module mac_sequencer #(
  parameter int OPSIZE = 8,
  parameter int ACCW   = 24,
  parameter int LENW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  mac_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_ACC,
    S_DONE
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [LENW-1:0]            r_cnt;
  logic signed [ACCW-1:0]     r_acc;
  logic                       r_ovf;
  logic signed [2*OPSIZE-1:0] r_prod;
  logic signed [OPSIZE-1:0]   r_mulA;
  logic signed [OPSIZE-1:0]   r_mulB;
  logic                       r_waitCnt;

  logic signed [ACCW-1:0]     w_prodExt;
  logic signed [ACCW-1:0]     w_sum;
  logic                       w_cmdFire;
  logic                       w_opFire;
  logic                       w_ovfStep;

  // cmd is gated by mul_ready so a mul left busy by a reset finishes before any new start
  assign w_cmdFire = (r_state == S_IDLE) && bus.cmd_valid && bus.mul_ready;
  assign w_opFire  = (r_state == S_FETCH) && bus.op_valid;

  assign w_prodExt = ACCW'(r_prod);
  assign w_sum     = r_acc + w_prodExt;
  assign w_ovfStep = (r_acc[ACCW-1] == w_prodExt[ACCW-1]) && (w_sum[ACCW-1] != r_acc[ACCW-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmdFire) begin
          w_next = (bus.cmd_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_opFire) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT_LO;
      end
      // a start the mul never saw leaves mul_ready high for two cycles; retry it
      S_WAIT_LO: begin
        if (!bus.mul_ready) begin
          w_next = S_WAIT_HI;
        end else if (r_waitCnt) begin
          w_next = S_ISSUE;
        end
      end
      S_WAIT_HI: begin
        if (bus.mul_ready) begin
          w_next = S_ACC;
        end
      end
      S_ACC: begin
        w_next = (r_cnt == LENW'(1)) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        if (bus.res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_prod    <= '0;
      r_mulA    <= '0;
      r_mulB    <= '0;
      r_waitCnt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmdFire) begin
            r_cnt <= bus.cmd_len;
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
        end
        S_FETCH: begin
          if (w_opFire) begin
            r_mulA <= bus.op_a;
            r_mulB <= bus.op_b;
          end
        end
        S_ISSUE: begin
          r_waitCnt <= 1'b0;
        end
        S_WAIT_LO: begin
          r_waitCnt <= 1'b1;
        end
        S_WAIT_HI: begin
          if (bus.mul_ready) begin
            r_prod <= bus.mul_out;
          end
        end
        S_ACC: begin
          r_acc <= w_sum;
          r_ovf <= r_ovf | w_ovfStep;
          r_cnt <= r_cnt - LENW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cmd_ready = w_cmdFire || ((r_state == S_IDLE) && bus.mul_ready);
  assign bus.op_ready  = (r_state == S_FETCH);
  assign bus.mul_start = (r_state == S_ISSUE);
  assign bus.mul_a     = r_mulA;
  assign bus.mul_b     = r_mulB;
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.res_data  = (r_state == S_DONE) ? r_acc : '0;
  assign bus.res_ovf   = (r_state == S_DONE) && r_ovf;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised bench for mac_sequencer with a behavioural mul (random latency,
// occasional lost starts) and a dot-product reference model.
module tb_mac_sequencer;

  localparam int OPSIZE = 8;
  localparam int ACCW   = 16;
  localparam int LENW   = 8;
  localparam int CYCLE_LIMIT = 400;
  localparam longint MAXV = (longint'(1) << (ACCW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACCW - 1));
  localparam longint MASK = (longint'(1) << ACCW) - 1;

  logic clk;
  logic rst;

  mac_sequencer_if #(.OPSIZE(OPSIZE), .ACCW(ACCW), .LENW(LENW)) bus ();

  mac_sequencer #(.OPSIZE(OPSIZE), .ACCW(ACCW), .LENW(LENW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int failures = 0;
  int startPulses = 0;
  int accepted = 0;
  int lastLat = 0;
  bit dropEnable = 0;
  longint lastData = 0;
  bit lastOvf = 0;
  longint modelData;
  bit modelOvf;
  int opA [256];
  int opB [256];
  longint expData [$];
  bit expOvf [$];

  int mPhase = 0;
  int mLeft = 0;
  logic signed [OPSIZE-1:0] mA = '0;
  logic signed [OPSIZE-1:0] mB = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests = tests + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural mul without reset: ready drops the edge after the start edge,
  // product appears after a random number of cycles.
  always @(posedge clk) begin
    case (mPhase)
      0: begin
        if (bus.mul_ready && bus.mul_start) begin
          if (dropEnable && ($urandom_range(0, 7) == 0)) begin
            mPhase <= 0;
          end else begin
            mA <= bus.mul_a;
            mB <= bus.mul_b;
            mPhase <= 1;
            accepted = accepted + 1;
          end
        end
      end
      1: begin
        bus.mul_ready <= 1'b0;
        mLeft <= int'($urandom_range(2, 6));
        mPhase <= 2;
      end
      default: begin
        if (mLeft <= 1) begin
          bus.mul_out <= 16'(mA) * 16'(mB);
          bus.mul_ready <= 1'b1;
          mPhase <= 0;
        end else begin
          mLeft <= mLeft - 1;
        end
      end
    endcase
  end

  // Compare process: result against the model queue, plus protocol rules.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (bus.mul_start) begin
        startPulses = startPulses + 1;
        checkOutput("mul_start only while mul_ready", bus.mul_ready, 1);
      end
      if (mPhase != 0 && bus.busy) begin
        checkOutput("mul_a held", longint'(bus.mul_a), longint'(mA));
        checkOutput("mul_b held", longint'(bus.mul_b), longint'(mB));
      end
      if (bus.res_valid) begin
        checkOutput("cmd_ready low while result pending", bus.cmd_ready, 0);
        checkOutput("op_ready low while result pending", bus.op_ready, 0);
        checkOutput("one result outstanding", expData.size(), 1);
        if (expData.size() > 0) begin
          checkOutput("res_data", longint'($signed(bus.res_data)), expData[0]);
          checkOutput("res_ovf", bus.res_ovf, expOvf[0]);
          if (bus.res_ready) begin
            lastData = longint'($signed(bus.res_data));
            lastOvf = bus.res_ovf;
            void'(expData.pop_front());
            void'(expOvf.pop_front());
          end
        end
      end
    end
  end

  task automatic computeModel(input int n, output longint data, output bit ovf);
    longint acc;
    longint s;
    acc = 0;
    ovf = 0;
    for (int i = 0; i < n; i++) begin
      s = acc + longint'(opA[i]) * longint'(opB[i]);
      if (s > MAXV || s < MINV) ovf = 1;
      s = s & MASK;
      if (s > MAXV) s = s - (longint'(1) << ACCW);
      acc = s;
    end
    data = acc;
  endtask

  task automatic sendCmd(input int n);
    int t;
    startPulses = 0;
    accepted = 0;
    bus.cmd_len = 8'(n);
    bus.cmd_valid = 1'b1;
    t = 0;
    while (!bus.cmd_ready && t < CYCLE_LIMIT) begin
      @(negedge clk);
      t++;
    end
    checkOutput("cmd accepted", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic sendPair(input int a, input int b, input int gap);
    int t;
    bus.op_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.op_a = 8'(a);
    bus.op_b = 8'(b);
    bus.op_valid = 1'b1;
    t = 0;
    while (!bus.op_ready && t < CYCLE_LIMIT) begin
      @(negedge clk);
      t++;
    end
    checkOutput("pair accepted", bus.op_ready, 1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_a = 8'($urandom_range(0, 255));
    bus.op_b = 8'($urandom_range(0, 255));
  endtask

  task automatic getResult(input int hold);
    int t;
    bus.res_ready = 1'b0;
    t = 0;
    while (!bus.res_valid && t < CYCLE_LIMIT) begin
      @(negedge clk);
      t++;
    end
    checkOutput("result produced", bus.res_valid, 1);
    lastLat = t + 1;
    repeat (hold) @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input int gapMax, input int hold);
    computeModel(n, modelData, modelOvf);
    expData.push_back(modelData);
    expOvf.push_back(modelOvf);
    sendCmd(n);
    for (int i = 0; i < n; i++) begin
      sendPair(opA[i], opB[i], int'($urandom_range(0, gapMax)));
    end
    getResult(hold);
    checkOutput("one accepted mul start per pair", accepted, n);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len = '0;
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.res_ready = 1'b0;
    bus.mul_ready = 1'b1;
    bus.mul_out = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset cmd_ready", bus.cmd_ready, 1);
    checkOutput("reset op_ready", bus.op_ready, 0);
    checkOutput("reset res_valid", bus.res_valid, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset mul_start", bus.mul_start, 0);
    checkOutput("reset res_data", longint'(bus.res_data), 0);
    checkOutput("reset mul_a/b", longint'({bus.mul_a, bus.mul_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T1
    opA[0] = 4; opB[0] = 6;
    applyStimulus(1, 0, 0);
    checkOutput("T1 model", modelData, 24);
    checkOutput("T1 res_data", lastData, 24);
    checkOutput("T1 res_ovf", lastOvf, 0);
    checkOutput("T1 mul_start pulses", startPulses, 1);

    // T2
    opA[0] = 4;  opB[0] = 6;
    opA[1] = -4; opB[1] = 6;
    opA[2] = 4;  opB[2] = -6;
    opA[3] = -4; opB[3] = -6;
    applyStimulus(4, 1, 1);
    checkOutput("T2a res_data", lastData, 0);
    opA[0] = 4;  opB[0] = 6;
    opA[1] = -1; opB[1] = -1;
    applyStimulus(2, 1, 0);
    checkOutput("T2b model", modelData, 25);
    checkOutput("T2b res_data", lastData, 25);

    // T3
    opA[0] = -128; opB[0] = -128;
    opA[1] = -128; opB[1] = -128;
    applyStimulus(2, 0, 0);
    checkOutput("T3 model", modelData, -32768);
    checkOutput("T3 res_data", lastData & MASK, 'h8000);
    checkOutput("T3 res_ovf", lastOvf, 1);

    // T4
    applyStimulus(0, 0, 0);
    checkOutput("T4 res_data", lastData, 0);
    checkOutput("T4 mul_start pulses", startPulses, 0);
    checkOutput("T4 latency in range", (lastLat >= 1 && lastLat <= 2), 1);

    // T5: result held for 10 cycles, operand gaps of 3 cycles
    opA[0] = 7; opB[0] = -9;
    opA[1] = 100; opB[1] = 100;
    opA[2] = -3; opB[2] = 11;
    computeModel(3, modelData, modelOvf);
    expData.push_back(modelData);
    expOvf.push_back(modelOvf);
    sendCmd(3);
    for (int i = 0; i < 3; i++) sendPair(opA[i], opB[i], 3);
    getResult(10);
    checkOutput("T5 res_data", lastData, 9904);
    checkOutput("T5 mul_start pulses", startPulses, 3);

    // T6: reset while pair 2 is inside the mul
    opA[0] = 10; opB[0] = 10;
    opA[1] = 20; opB[1] = 20;
    sendCmd(3);
    sendPair(opA[0], opB[0], 0);
    sendPair(opA[1], opB[1], 0);
    t = 0;
    while (!(bus.busy && !bus.mul_ready && mPhase == 2) && t < CYCLE_LIMIT) begin
      @(negedge clk);
      t++;
    end
    checkOutput("T6 reached WAIT_HI", (bus.busy && !bus.mul_ready), 1);
    rst = 1'b1;
    #1;
    checkOutput("T6 busy after reset", bus.busy, 0);
    checkOutput("T6 op_ready after reset", bus.op_ready, 0);
    checkOutput("T6 res_valid after reset", bus.res_valid, 0);
    checkOutput("T6 mul_start after reset", bus.mul_start, 0);
    checkOutput("T6 cmd_ready waits for mul", bus.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (!bus.cmd_ready && t < CYCLE_LIMIT) begin
      checkOutput("T6 cmd_ready low while mul busy", bus.cmd_ready, 0);
      @(negedge clk);
      t++;
    end
    checkOutput("T6 mul_ready up when cmd_ready rises", bus.mul_ready, 1);
    opA[0] = 3; opB[0] = -5;
    applyStimulus(1, 0, 0);
    checkOutput("T6 model", modelData, -15);
    checkOutput("T6 res_data", lastData, -15);

    // Random commands with lost mul starts injected
    dropEnable = 1;
    for (int c = 0; c < 40; c++) begin
      int n;
      n = (c == 20) ? 255 : int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) begin
        opA[i] = ($urandom_range(0, 3) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
        opB[i] = ($urandom_range(0, 3) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
      end
      applyStimulus(n, 2, int'($urandom_range(0, 3)));
    end
    dropEnable = 0;

    repeat (3) @(negedge clk);
    checkOutput("no result left pending", expData.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
